// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a NUM_DIGITS-digit common-anode seven-segment
//   display. A shadow register captures the value on `load`. The shadow is
//   copied into the displayed (active) register only at a frame boundary, so a
//   frame never shows a mix of old and new digits. Each digit slot lasts
//   REFRESH_DIV cycles. The first BLANK_CYCLES of every slot keep all anodes
//   off, which suppresses ghosting between digits.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   value        hex nibbles, nibble i drives digit i (digit 0 is rightmost)
//   load         one-cycle strobe that captures value into the shadow register
//   digit_en     per-digit enable (live)
//   dp_mask      per-digit decimal point request (live)
//   lz_en        leading-zero suppression enable (live)
//   dig          segments {a..g}, active-low
//   seg          anode enables, active-low, at most one bit low
//   dp_n         decimal point, active-low
//   frame_tick   one-cycle pulse, the cycle after each frame commit
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_en,
  output logic [6:0]              dig,
  output logic [NUM_DIGITS-1:0]   seg,
  output logic                    dp_n,
  output logic                    frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic [VAL_W-1:0]      active_q, active_d;
  logic                  pending_q, pending_d;
  logic [6:0]            dig_q, dig_d;
  logic [NUM_DIGITS-1:0] seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  cnt_wrap;
  logic                  commit;
  logic                  blank_done;
  logic [NUM_DIGITS-1:0] supp;
  logic [3:0]            cur_nib;
  logic                  cur_en;
  logic                  cur_dp;
  logic                  cur_supp;
  logic                  lit;

  function automatic logic [6:0] encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0001100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b1110010;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // With no blanking gap, the comparison against zero would be constant, so
  // the gap logic is only built when a gap exists.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign blank_done = 1'b1;
    end else begin : g_blank
      assign blank_done = (cnt_q >= CNT_BLANK);
    end
  endgenerate

  assign cnt_wrap = (cnt_q == CNT_LAST);
  assign commit   = cnt_wrap && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // The commit reads shadow_q, so a load on the commit cycle stays pending
  // for the following frame.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    active_d  = active_q;
    if (commit && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end
  end

  // Scan from the top digit down. A digit is suppressed while every nibble
  // from it upward is zero. Digit 0 always shows.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    supp     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (active_q[4*i +: 4] == 4'h0);
      if (i > 0) begin
        supp[i] = lz_en && zero_run;
      end
    end
  end

  always_comb begin
    cur_nib  = 4'h0;
    cur_en   = 1'b0;
    cur_dp   = 1'b0;
    cur_supp = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        cur_nib  = active_q[4*i +: 4];
        cur_en   = digit_en[i];
        cur_dp   = dp_mask[i];
        cur_supp = supp[i];
      end
    end
  end

  assign lit = blank_done && cur_en && !cur_supp;

  always_comb begin
    seg_d        = '1;
    dig_d        = 7'b111_1111;
    dp_n_d       = 1'b1;
    frame_tick_d = commit;
    if (lit) begin
      seg_d  = ~(NUM_DIGITS'(1) << idx_q);
      dig_d  = encode(cur_nib);
      dp_n_d = ~cur_dp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      dig_q        <= 7'b111_1111;
      seg_q        <= '1;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      dig_q        <= dig_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign dig        = dig_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. `cyc` counts clock edges since reset release. Outputs seen
// after edge k reflect cnt=(k-1)%8 and idx=((k-1)/8)%4. Digit d of frame f
// therefore lights from edge f*32+d*8+3 through edge f*32+d*8+8.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  digit_en;
  logic [3:0]  dp_mask;
  logic        lz_en;
  logic [6:0]  dig;
  logic [3:0]  seg;
  logic        dp_n;
  logic        frame_tick;

  int cyc;
  int checks;
  int errors;

  localparam logic [6:0] D_OFF = 7'b1111111;
  localparam logic [6:0] D_0   = 7'b0000001;
  localparam logic [6:0] D_1   = 7'b1001111;
  localparam logic [6:0] D_2   = 7'b0010010;
  localparam logic [6:0] D_3   = 7'b0000110;
  localparam logic [6:0] D_5   = 7'b0100100;
  localparam logic [6:0] D_7   = 7'b0001111;
  localparam logic [6:0] D_A   = 7'b0001000;
  localparam logic [6:0] D_C   = 7'b1110010;

  seg7_scan_driver #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .load      (load),
    .digit_en  (digit_en),
    .dp_mask   (dp_mask),
    .lz_en     (lz_en),
    .dig       (dig),
    .seg       (seg),
    .dp_n      (dp_n),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [3:0] s_exp,
                     input logic [6:0] d_exp, input logic p_exp);
    checks++;
    assert (seg === s_exp) else begin
      errors++;
      $error("FAIL %s seg: got %b want %b (cyc %0d)", tag, seg, s_exp, cyc);
    end
    checks++;
    assert (dig === d_exp) else begin
      errors++;
      $error("FAIL %s dig: got %b want %b (cyc %0d)", tag, dig, d_exp, cyc);
    end
    checks++;
    assert (dp_n === p_exp) else begin
      errors++;
      $error("FAIL %s dp_n: got %b want %b (cyc %0d)", tag, dp_n, p_exp, cyc);
    end
  endtask

  task automatic chk_tick(input string tag, input logic t_exp);
    checks++;
    assert (frame_tick === t_exp) else begin
      errors++;
      $error("FAIL %s frame_tick: got %b want %b (cyc %0d)", tag, frame_tick, t_exp, cyc);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    rst      = 1'b0;
    value    = 16'h0000;
    load     = 1'b0;
    digit_en = 4'b1111;
    dp_mask  = 4'b0000;
    lz_en    = 1'b0;

    #1 rst = 1'b1;
    #2;
    chk("reset", 4'b1111, D_OFF, 1'b1);
    chk_tick("reset", 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    // Idle scan showing zero
    go(1);  chk("idle_blank0", 4'b1111, D_OFF, 1'b1);
    go(2);  chk("idle_blank1", 4'b1111, D_OFF, 1'b1);
    go(3);  chk("idle_d0_first", 4'b1110, D_0, 1'b1);
    go(8);  chk("idle_d0_last", 4'b1110, D_0, 1'b1);
    go(9);  chk("idle_gap", 4'b1111, D_OFF, 1'b1);
    go(11); chk("idle_d1", 4'b1101, D_0, 1'b1);
    go(31); chk_tick("tick_before", 1'b0);
    go(32); chk_tick("tick_first", 1'b1);
    go(33); chk_tick("tick_after", 1'b0);

    // Shadowed load: nothing changes until the commit at edge 64
    go(40); do_load(16'hA5C3);
    go(43); chk("load_no_change", 4'b1101, D_0, 1'b1);
    go(64); chk("pre_commit_d3", 4'b0111, D_0, 1'b1);
    chk_tick("tick_second", 1'b1);
    go(65); chk("post_commit_blank", 4'b1111, D_OFF, 1'b1);
    go(67); chk("a5c3_d0", 4'b1110, D_3, 1'b1);
    go(75); chk("a5c3_d1", 4'b1101, D_C, 1'b1);
    go(83); chk("a5c3_d2", 4'b1011, D_5, 1'b1);
    go(91); chk("a5c3_d3", 4'b0111, D_A, 1'b1);

    // Leading-zero suppression
    go(92); lz_en = 1'b1; do_load(16'h0007);
    go(99);  chk("lz7_d0", 4'b1110, D_7, 1'b1);
    go(107); chk("lz7_d1", 4'b1111, D_OFF, 1'b1);
    go(115); chk("lz7_d2", 4'b1111, D_OFF, 1'b1);
    go(123); chk("lz7_d3", 4'b1111, D_OFF, 1'b1);
    go(124); do_load(16'h0000);
    go(131); chk("lz0_d0", 4'b1110, D_0, 1'b1);
    go(139); chk("lz0_d1", 4'b1111, D_OFF, 1'b1);

    // Per-digit enable and decimal points
    go(140); lz_en = 1'b0; digit_en = 4'b1011; dp_mask = 4'b0010;
    go(147); chk("en_d2_dark", 4'b1111, D_OFF, 1'b1);
    go(155); chk("en_d3", 4'b0111, D_0, 1'b1);
    go(163); chk("en_d0", 4'b1110, D_0, 1'b1);
    go(171); chk("dp_d1", 4'b1101, D_0, 1'b0);

    // Last load in a frame wins
    go(172); digit_en = 4'b1111; dp_mask = 4'b0000;
    do_load(16'h1111);
    go(180); do_load(16'h2222);
    go(192); chk("multi_pre_commit", 4'b0111, D_0, 1'b1);
    go(195); chk("multi_d0", 4'b1110, D_2, 1'b1);
    go(203); chk("multi_d1", 4'b1101, D_2, 1'b1);

    // Load on the commit cycle (edge 224) stays pending for one more frame
    go(210); do_load(16'h1111);
    go(223); do_load(16'h3333);
    go(227); chk("cc_old_d0", 4'b1110, D_1, 1'b1);
    go(235); chk("cc_old_d1", 4'b1101, D_1, 1'b1);
    go(256); chk("cc_old_d3", 4'b0111, D_1, 1'b1);
    go(259); chk("cc_new_d0", 4'b1110, D_3, 1'b1);

    // Reset in the middle of slot 2
    go(277); chk("pre_reset_d2", 4'b1011, D_3, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_reset", 4'b1111, D_OFF, 1'b1);
    chk_tick("mid_reset", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    go(1);  chk("rr_blank", 4'b1111, D_OFF, 1'b1);
    go(3);  chk("rr_d0", 4'b1110, D_0, 1'b1);
    go(11); chk("rr_d1", 4'b1101, D_0, 1'b1);
    go(31); chk_tick("rr_tick_before", 1'b0);
    go(32); chk_tick("rr_tick", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for an NUM_DIGITS-digit common-anode seven-segment display; next generation of the single-digit hex-to-segment decoder.
- Holds a tear-free display value, scans one digit at a time at a programmable refresh rate, and inserts ghost-blanking gaps between digits.
- Adds per-digit enable, decimal points and leading-zero suppression.
- Sits between core logic (key/value registers) and the board's segment/anode pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (>=1).
- REFRESH_DIV, 50000, clock cycles per digit slot (> BLANK_CYCLES).
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off (>=0).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i (value[4i+3:4i]) drives digit i; digit 0 is rightmost.
- load  in  1  one-cycle strobe; captures value into the shadow register.
- digit_en  in  NUM_DIGITS  per-digit enable (1 = may light).
- dp_mask  in  NUM_DIGITS  per-digit decimal point request (1 = on).
- lz_en  in  1  leading-zero suppression enable.
- dig  out  7  segments {a,b,c,d,e,f,g}, bit6 = a, active-low.
- seg  out  NUM_DIGITS  anode enables, active-low, one-hot-low or all-high.
- dp_n  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Reset (async, immediate): dig = 7'b111_1111, seg = all ones, dp_n = 1, frame_tick = 0, slot counter cnt = 0, scan index idx = 0, shadow = 0, active = 0, pending = 0.
- Counters: cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - On cnt wrap, idx advances and wraps from NUM_DIGITS-1 to 0.
  - A frame commit occurs on the cycle where cnt wraps and idx wraps. On that cycle:
    - if pending, active <= shadow and pending <= 0;
    - frame_tick is asserted in the following cycle.
- Load:
  - load = 1 sets shadow <= value and pending <= 1.
  - Multiple loads within a frame: the last one wins.
  - Load on the commit cycle: the commit takes the old shadow; the new value stays pending for the next frame.
- Segment encoding (active-low), nibble -> dig:
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110
  - 4 1001100, 5 0100100, 6 0100000, 7 0001111
  - 8 0000000, 9 0001100, A 0001000, b 1100000
  - c 1110010, d 1000010, E 0110000, F 0111000
- Suppression: digit i (i>0) is suppressed when lz_en = 1 and nibbles i..NUM_DIGITS-1 of active are all zero. Digit 0 is never suppressed.
- Lighting rule: digit idx is lit iff cnt >= BLANK_CYCLES, digit_en[idx] = 1, and it is not suppressed.
- Output registers: all outputs are registered, one cycle after the (cnt, idx) they reflect.
  - Lit: seg[idx] = 0 (others 1), dig = encode(active nibble idx), dp_n = ~dp_mask[idx].
  - Not lit: seg = all ones, dig = 7'b111_1111, dp_n = 1.
- Invariant: at most one seg bit is low on any cycle.
- Timing-only inputs: digit_en, dp_mask and lz_en are sampled live every cycle (not shadowed).
- NUM_DIGITS = 1: idx is constant 0, and every slot wrap is a commit.
- BLANK_CYCLES = 0: no gap; anodes switch directly between digits.
- Reset mid-scan: all state returns to reset values; the first frame restarts at idx 0, cnt 0, and the display shows 0 (not lit until BLANK_CYCLES have elapsed).

Test Plan:
(Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.)
- Reset, no load -> seg=1111 and dig=1111111 during cycles 0..2. Then seg=1110, dig=0000001 for 6 cycles, then 2 blank cycles, then seg=1101. frame_tick pulses every 32 cycles.
- load with value=16'hA5C3, all digit_en, dp_mask=0 -> nothing changes until the next frame commit. Then the per-slot outputs are:
  - seg=1110 with dig=0000110 (3)
  - seg=1101 with dig=1110010 (c)
  - seg=1011 with dig=0100100 (5)
  - seg=0111 with dig=0001000 (A)
- lz_en=1 with value=16'h0007 -> only slot 0 lights (dig=0001111); slots 1..3 keep seg=1111. With value=0: digit 0 still shows 0000001.
- digit_en=4'b1011, dp_mask=4'b0010 -> slot 2 dark. Slot 1 has dp_n=0; the other lit slots have dp_n=1.
- Loads: loads of 16'h1111 then 16'h2222 in the same frame -> only 2222 is displayed next frame. A load of 16'h3333 on the commit cycle -> the old shadow is committed, and 3333 appears one frame later.
- Assert rst mid-slot (idx=2) -> outputs go all-ones immediately. After release, the scan restarts at idx 0 showing 0 (active cleared).
